// File: rtl/ex_men_skid.sv
// EX -> MEN pipeline register with a one-entry skid buffer.
// The main register drives the MEN side; the skid register catches the one
// entry that arrives in the cycle downstream stalls, so in_ready is a pure
// register output and never depends combinationally on out_ready.
module ex_men_skid #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int OP_W      = 8,
    parameter int CNT_W     = 16,
    parameter int ZERO_KILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_w_reg_data,
    input  logic [DATA_W-1:0] in_inst_addr,
    input  logic [DATA_W-1:0] in_data_use,
    input  logic [ADDR_W-1:0] in_w_reg_addr,
    input  logic              in_wd,
    input  logic [OP_W-1:0]   in_aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_w_reg_data,
    output logic [DATA_W-1:0] out_inst_addr,
    output logic [DATA_W-1:0] out_data_use,
    output logic [ADDR_W-1:0] out_w_reg_addr,
    output logic              out_wd,
    output logic [OP_W-1:0]   out_aluop,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload packed as {w_reg_data, inst_addr, data_use, w_reg_addr, wd, aluop}
    localparam int PW = 3 * DATA_W + ADDR_W + 1 + OP_W;

    logic [PW-1:0]    in_pld;
    logic [PW-1:0]    main_pld_reg, main_pld_next;
    logic [PW-1:0]    skid_pld_reg, skid_pld_next;
    logic             main_valid_reg, main_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             in_wd_cap;
    logic             main_wd;
    logic             accept;
    logic             consume;

    // A write to register 0 is meaningless, so optionally drop its enable on capture
    generate
        if (ZERO_KILL != 0) begin : g_zero_kill
            assign in_wd_cap = in_wd & (|in_w_reg_addr);
        end else begin : g_no_zero_kill
            assign in_wd_cap = in_wd;
        end
    endgenerate

    assign in_pld = {in_w_reg_data, in_inst_addr, in_data_use,
                     in_w_reg_addr, in_wd_cap, in_aluop};

    // Ready whenever the skid slot is free; held low while in reset
    assign in_ready  = rst & ~skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign accept    = in_valid & in_ready;
    assign consume   = main_valid_reg & out_ready;

    assign {out_w_reg_data, out_inst_addr, out_data_use,
            out_w_reg_addr, main_wd, out_aluop} = main_pld_reg;
    assign out_wd    = main_wd & main_valid_reg;
    assign stall_cnt = stall_cnt_reg;

    // Next-state for the two slots and the saturating stall counter
    always_comb begin
        main_pld_next   = main_pld_reg;
        skid_pld_next   = skid_pld_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        stall_cnt_next  = stall_cnt_reg;

        if (main_valid_reg && !out_ready && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (flush) begin
            // Flush wins over handshakes; payload may stay stale
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg) begin
            // EMPTY
            if (accept) begin
                main_pld_next   = in_pld;
                main_valid_next = 1'b1;
            end
        end else if (!skid_valid_reg) begin
            // ONE
            if (accept && consume) begin
                main_pld_next = in_pld;
            end else if (accept) begin
                skid_pld_next   = in_pld;
                skid_valid_next = 1'b1;
            end else if (consume) begin
                main_valid_next = 1'b0;
            end
        end else begin
            // TWO: nothing accepted, skid slides forward on consume
            if (consume) begin
                main_pld_next   = skid_pld_reg;
                skid_valid_next = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_pld_reg   <= '0;
            skid_pld_reg   <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            main_pld_reg   <= main_pld_next;
            skid_pld_reg   <= skid_pld_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_ex_men_skid.sv
// Bench for ex_men_skid: two instances share stimulus (defaults, and
// ZERO_KILL=0 with a 4-bit stall counter). A queue model predicts outputs.
module tb_ex_men_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_w_reg_data, in_inst_addr, in_data_use;
    logic [4:0]  in_w_reg_addr;
    logic        in_wd;
    logic [7:0]  in_aluop;

    logic        r1, v1, wd1, r2, v2, wd2;
    logic [31:0] d1, ia1, du1, d2, ia2, du2;
    logic [4:0]  a1, a2;
    logic [7:0]  op1, op2;
    logic [15:0] sc1;
    logic [3:0]  sc2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_men_skid dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_w_reg_data(in_w_reg_data), .in_inst_addr(in_inst_addr), .in_data_use(in_data_use),
        .in_w_reg_addr(in_w_reg_addr), .in_wd(in_wd), .in_aluop(in_aluop),
        .out_valid(v1), .out_ready(out_ready),
        .out_w_reg_data(d1), .out_inst_addr(ia1), .out_data_use(du1),
        .out_w_reg_addr(a1), .out_wd(wd1), .out_aluop(op1), .stall_cnt(sc1)
    );

    ex_men_skid #(.CNT_W(4), .ZERO_KILL(0)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r2),
        .in_w_reg_data(in_w_reg_data), .in_inst_addr(in_inst_addr), .in_data_use(in_data_use),
        .in_w_reg_addr(in_w_reg_addr), .in_wd(in_wd), .in_aluop(in_aluop),
        .out_valid(v2), .out_ready(out_ready),
        .out_w_reg_data(d2), .out_inst_addr(ia2), .out_data_use(du2),
        .out_w_reg_addr(a2), .out_wd(wd2), .out_aluop(op2), .stall_cnt(sc2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] data, inst, use_d;
        logic [4:0]  waddr;
        logic        wd;
        logic [7:0]  op;
    } entry_t;

    entry_t q[$];
    int     m_cnt1 = 0;
    int     m_cnt2 = 0;
    bit     m_in_reset = 0;
    bit     started = 0;

    // FIFO of at most two entries; flush empties it, reset empties and zeroes
    always @(posedge clk) begin
        bit     acc, con;
        entry_t e;
        acc = in_valid && rst && (q.size() < 2);
        con = (q.size() > 0) && out_ready;
        started = 1;
        if (!rst) begin
            q.delete();
            m_cnt1 = 0;
            m_cnt2 = 0;
            m_in_reset = 1;
        end else begin
            m_in_reset = 0;
            if (q.size() > 0 && !out_ready) begin
                if (m_cnt1 < 65535) m_cnt1++;
                if (m_cnt2 < 15) m_cnt2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) begin
                    e.data = in_w_reg_data; e.inst = in_inst_addr; e.use_d = in_data_use;
                    e.waddr = in_w_reg_addr; e.wd = in_wd; e.op = in_aluop;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready1", r1, rst && (q.size() < 2));
            chk("in_ready2", r2, rst && (q.size() < 2));
            chk("out_valid1", v1, q.size() > 0);
            chk("out_valid2", v2, q.size() > 0);
            chk("stall_cnt1", sc1, m_cnt1);
            chk("stall_cnt2", sc2, m_cnt2);
            if (q.size() > 0) begin
                chk("data1", d1, q[0].data);   chk("data2", d2, q[0].data);
                chk("inst1", ia1, q[0].inst);  chk("inst2", ia2, q[0].inst);
                chk("use1", du1, q[0].use_d);  chk("use2", du2, q[0].use_d);
                chk("waddr1", a1, q[0].waddr); chk("waddr2", a2, q[0].waddr);
                chk("aluop1", op1, q[0].op);   chk("aluop2", op2, q[0].op);
                chk("wd1", wd1, q[0].wd && (q[0].waddr != 0));
                chk("wd2", wd2, q[0].wd);
            end else begin
                chk("wd1_bubble", wd1, 0);
                chk("wd2_bubble", wd2, 0);
            end
            if (m_in_reset) begin
                chk("rst_payload1", {d1, ia1, du1, a1, op1}, 0);
                chk("rst_payload2", {d2, ia2, du2, a2, op2}, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [31:0] inst, input logic [31:0] data,
                        input logic [4:0] waddr, input logic wd);
        in_valid      = v;
        in_inst_addr  = inst;
        in_w_reg_data = data;
        in_data_use   = inst ^ 32'h5A5A_0000;
        in_w_reg_addr = waddr;
        in_wd         = wd;
        in_aluop      = inst[7:0] + 8'h11;
    endtask

    int nout;

    initial begin
        rst = 0; flush = 0; out_ready = 0;
        push(0, 0, 0, 0, 0);

        // reset
        tick(); tick();
        $display("[TB] reset held two cycles");
        chk("reset_out_valid", v1, 0);
        chk("reset_in_ready", r1, 0);
        chk("reset_data", d1, 0);
        chk("reset_stall", sc1, 0);

        // single entry after reset
        rst = 1; out_ready = 1;
        push(1, 32'h100, 32'hDEADBEEF, 5, 1);
        #1 chk("ready_after_reset", r1, 1);
        tick();
        push(0, 0, 0, 0, 0);
        $display("[TB] single entry DEADBEEF");
        chk("single_valid", v1, 1);
        chk("single_data", d1, 32'hDEADBEEF);
        chk("single_wd", wd1, 1);
        tick();

        // back-pressure: A then B
        out_ready = 0;
        push(1, 32'hA, 32'h1111, 3, 1); tick();
        push(1, 32'hB, 32'h2222, 4, 1); tick();
        push(0, 0, 0, 0, 0);
        tick(); tick(); tick();
        $display("[TB] back-pressure A,B held");
        chk("bp_in_ready", r1, 0);
        chk("bp_head", ia1, 32'hA);
        chk("bp_stall", sc1, 4);
        out_ready = 1; tick();
        $display("[TB] back-pressure consume A");
        chk("bp_second", ia1, 32'hB);
        chk("bp_ready_back", r1, 1);
        tick();
        $display("[TB] back-pressure consume B");
        chk("bp_drained", v1, 0);

        // reset, then streaming 100 entries
        rst = 0; tick(); rst = 1;
        nout = 0;
        for (int i = 0; i < 100; i++) begin
            push(1, 32'h1000 + i, 32'h3000 + i, 5'(i % 32), 1);
            tick();
            chk("stream_in_ready", r1, 1);
            if (v1) nout++;
        end
        push(0, 0, 0, 0, 0);
        $display("[TB] streaming 100 entries");
        chk("stream_count", nout, 100);
        chk("stream_last", ia1, 32'h1000 + 99);
        chk("stream_stall", sc1, 0);
        tick();

        // flush while full with a simultaneous input
        out_ready = 0;
        push(1, 32'hC, 32'h4444, 6, 1); tick();
        push(1, 32'hD, 32'h5555, 7, 1); tick();
        flush = 1;
        push(1, 32'hE, 32'h6666, 8, 1); tick();
        flush = 0;
        push(0, 0, 0, 0, 0);
        $display("[TB] flush in full state");
        chk("flush_valid", v1, 0);
        chk("flush_wd", wd1, 0);
        chk("flush_ready", r1, 1);
        out_ready = 1;
        tick(); tick();
        chk("flush_no_leak", v1, 0);

        // zero-kill, then stall saturation
        out_ready = 0;
        push(1, 32'hF0, 32'h55, 0, 1); tick();
        push(0, 0, 0, 0, 0);
        $display("[TB] zero-kill addr=0 wd=1");
        chk("zk_wd_on", wd1, 0);
        chk("zk_wd_off", wd2, 1);
        chk("zk_data", d1, 32'h55);
        for (int i = 0; i < 20; i++) tick();
        $display("[TB] stall saturation");
        chk("sat_cnt", sc2, 15);
        tick();
        chk("sat_hold", sc2, 15);

        // reset mid-operation discards stored entries
        push(1, 32'hF1, 32'h77, 9, 1); tick();
        rst = 0; tick();
        chk("midrst_valid", v1, 0);
        rst = 1;
        push(1, 32'hF2, 32'h88, 10, 1); tick();
        push(0, 0, 0, 0, 0);
        $display("[TB] reset mid-operation");
        chk("midrst_only", ia1, 32'hF2);
        out_ready = 1; tick();
        chk("midrst_drained", v1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_men_skid.md
EX_MEN_SKID -- requirements
Module: ex_men_skid

Interface
REQ-001 Parameter DATA_W, default 32: width of register-write data, instruction address and store data.
REQ-002 Parameter ADDR_W, default 5: destination register address width.
REQ-003 Parameter OP_W, default 8: ALU opcode width.
REQ-004 Parameter CNT_W, default 16: stall counter width.
REQ-005 Parameter ZERO_KILL, default 1: when 1, entries whose destination address is 0 have their write enable cleared on capture.
REQ-006 Port: clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-007 Port: rst, input, 1, reset; synchronous, active-low.
REQ-008 Port: flush, input, 1, synchronous pipeline flush.
REQ-009 Port: in_valid, input, 1, upstream (EX) entry valid.
REQ-010 Port: in_ready, output, 1, stage can accept an entry this cycle.
REQ-011 Port: in_w_reg_data / in_inst_addr / in_data_use, input, DATA_W each; payload.
REQ-012 Port: in_w_reg_addr, input, ADDR_W; in_wd, input, 1; in_aluop, input, OP_W; payload.
REQ-013 Port: out_valid, output, 1, entry presented to MEN.
REQ-014 Port: out_ready, input, 1, downstream consumes the entry.
REQ-015 Port: out_w_reg_data / out_inst_addr / out_data_use, output, DATA_W; out_w_reg_addr, output, ADDR_W; out_wd, output, 1; out_aluop, output, OP_W.
REQ-016 Port: stall_cnt, output, CNT_W, saturating count of back-pressured cycles.

Function
REQ-017 Storage: one main register (drives out_*) and one skid register, each with a valid bit; the states are EMPTY (none valid), ONE (main valid), TWO (both valid).
REQ-018 accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL be 0 while rst is low; it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-021 EMPTY: accept -> ONE, main <= in; otherwise stay.
REQ-022 ONE: accept & consume -> ONE, main <= in; accept only -> TWO, skid <= in; consume only -> EMPTY; neither -> hold.
REQ-023 TWO: consume -> ONE, main <= skid; otherwise hold; no input is accepted.
REQ-024 Latency: an entry accepted in EMPTY SHALL appear on out_* with out_valid=1 the next cycle; entries SHALL leave in acceptance order, with none lost or duplicated.
REQ-025 Payload SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 out_wd SHALL equal main wd AND out_valid; it is never 1 on a bubble.
REQ-027 With ZERO_KILL=1, an entry captured with in_w_reg_addr==0 SHALL store wd=0, and all other fields unchanged.
REQ-028 flush=1: next state EMPTY and both valid bits cleared; any accept in the same cycle is discarded, since flush has priority over accept and consume; payload registers may hold stale values.
REQ-029 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and not be cleared by flush.

Reset
REQ-030 When rst=0 at a clk edge: state EMPTY, both valid bits 0, all payload registers and outputs 0, stall_cnt 0; reset has priority over flush and over all handshakes.
REQ-031 Reset asserted mid-operation SHALL discard both stored entries; the first accept after rst returns to 1 SHALL appear one cycle later as the only entry.

Verification
REQ-032 Reset then single entry: rst low 2 cycles, then in_valid=1 with w_reg_data=0xDEADBEEF, addr=5, wd=1, out_ready=1 -> the next cycle shows out_valid=1, out_w_reg_data=0xDEADBEEF, out_wd=1; all outputs are 0 during reset.
REQ-033 Back-pressure: out_ready=0, push A then B -> state TWO, in_ready=0, out shows A; assert out_ready -> A, then B, in order, and in_ready returns to 1 after the first consume; stall_cnt equals the number of cycles with out_valid=1 and out_ready=0.
REQ-034 Streaming: in_valid=out_ready=1 for 100 cycles with incrementing inst_addr -> 100 outputs in order, in_ready constantly 1, stall_cnt=0.
REQ-035 Flush in TWO with simultaneous in_valid=1 -> the next cycle has out_valid=0, out_wd=0, in_ready=1, and the flushed-cycle input never appears.
REQ-036 ZERO_KILL: push addr=0, wd=1 -> out_wd=0 and the other fields pass through; with ZERO_KILL=0 -> out_wd=1.
REQ-037 Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and it stays 15.
